// File: rtl/torreta_uc_pkg.sv
// Shared definitions for the turret control unit: state codes, strobe bundle
// and the default measurement watchdog limit.
package torreta_uc_pkg;

  localparam int TIMEOUT_MEDIDA_DEFAULT = 2_500_000;
  localparam int N_TIMEOUT_DEFAULT      = 22;

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    MEDIR         = 4'h2,
    ESPERA_MEDIDA = 4'h3,
    TRANSMITE     = 4'h4,
    ESPERA_ENVIO  = 4'h5,
    AVALIA        = 4'h6,
    ESPERA_TEMPO  = 4'h7,
    GIRA          = 4'h8,
    ARMA          = 4'h9,
    DISPARA       = 4'hA,
    RECARREGA     = 4'hB,
    CARREGA       = 4'hC
  } estado_t;

  typedef struct packed {
    logic medir;
    logic transmitir;
    logic girar;
    logic conta_tempo;
    logic armar_disparo;
    logic disparar;
    logic recarregar_disparo;
    logic conta_municao;
  } strobes_t;

  // Moore decode: the strobe set that belongs to each state.
  function automatic strobes_t strobes_de(estado_t e);
    strobes_t s;
    s = '0;
    case (e)
      MEDIR:        s.medir              = 1'b1;
      TRANSMITE:    s.transmitir         = 1'b1;
      GIRA:         s.girar              = 1'b1;
      ESPERA_TEMPO: s.conta_tempo        = 1'b1;
      ARMA:         s.armar_disparo      = 1'b1;
      DISPARA:      s.disparar           = 1'b1;
      RECARREGA:    s.recarregar_disparo = 1'b1;
      CARREGA:      s.conta_municao      = 1'b1;
      default:      s                    = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with async clear and synchronous clear.
module contador_m #(
  parameter int M = 100,
  parameter int N = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera_s,
  input  logic         conta,
  output logic [N-1:0] q
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          q <= '0;
    else if (zera_s)     q <= '0;
    else if (conta)      q <= (q == N'(M - 1)) ? '0 : q + 1'b1;
  end

endmodule

// File: rtl/torreta_uc.sv
// Turret scan-step control unit: sequences measure, transmit, evaluate,
// optional arm/fire/reload, inter-rotation wait and base rotation.
module torreta_uc
  import torreta_uc_pkg::*;
#(
  parameter int TIMEOUT_MEDIDA = TIMEOUT_MEDIDA_DEFAULT,
  parameter int N_TIMEOUT      = N_TIMEOUT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       carregar,
  input  logic       medida_pronto,
  input  logic       envio_pronto,
  input  logic       fim_tempo,
  input  logic       ameaca_detectada,
  input  logic       municao_carregada,
  input  logic       disparo_pronto,
  input  logic       fim_disparo,
  input  logic       disparo_carregado,
  output logic       medir,
  output logic       transmitir,
  output logic       girar,
  output logic       conta_tempo,
  output logic       armar_disparo,
  output logic       disparar,
  output logic       recarregar_disparo,
  output logic       conta_municao,
  output logic       erro_medida,
  output logic [3:0] db_estado
);

  estado_t              estado, proximo;
  strobes_t             saidas;
  logic [N_TIMEOUT-1:0] contagem;
  logic                 fim_timeout;

  assign fim_timeout = (contagem == N_TIMEOUT'(TIMEOUT_MEDIDA - 1));

  // Gating conta with fim_timeout makes the wrapping counter saturate.
  contador_m #(.M(TIMEOUT_MEDIDA), .N(N_TIMEOUT)) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .zera_s (estado == MEDIR),
    .conta  ((estado == ESPERA_MEDIDA) && !fim_timeout),
    .q      (contagem)
  );

  // NOTE: every path assigns proximo via the default first, so no latch forms.
  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:       if (ligar) proximo = PREPARACAO;
                     else if (carregar) proximo = CARREGA;
      CARREGA:       if (!carregar) proximo = INICIAL;
      PREPARACAO:    proximo = MEDIR;
      MEDIR:         proximo = ESPERA_MEDIDA;
      ESPERA_MEDIDA: if (!ligar) proximo = INICIAL;
                     else if (medida_pronto) proximo = TRANSMITE;
                     else if (fim_timeout) proximo = ESPERA_TEMPO;
      TRANSMITE:     proximo = ESPERA_ENVIO;
      ESPERA_ENVIO:  if (!ligar) proximo = INICIAL;
                     else if (envio_pronto) proximo = AVALIA;
      AVALIA:        proximo = (ameaca_detectada && municao_carregada) ? ARMA : ESPERA_TEMPO;
      ARMA:          if (disparo_pronto) proximo = DISPARA;
      DISPARA:       if (fim_disparo) proximo = RECARREGA;
      RECARREGA:     if (disparo_carregado) proximo = ESPERA_TEMPO;
      ESPERA_TEMPO:  if (!ligar) proximo = INICIAL;
                     else if (fim_tempo) proximo = GIRA;
      GIRA:          proximo = ligar ? MEDIR : INICIAL;
      default:       proximo = INICIAL;
    endcase
  end

  // Strobes are registered from the next state so they assert in the first
  // cycle of their state and drop immediately on async reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= INICIAL;
      saidas      <= '0;
      erro_medida <= 1'b0;
    end else begin
      estado <= proximo;
      saidas <= strobes_de(proximo);
      if (estado == ESPERA_MEDIDA && ligar) begin
        if (medida_pronto)    erro_medida <= 1'b0;
        else if (fim_timeout) erro_medida <= 1'b1;
      end
    end
  end

  assign medir              = saidas.medir;
  assign transmitir         = saidas.transmitir;
  assign girar              = saidas.girar;
  assign conta_tempo        = saidas.conta_tempo;
  assign armar_disparo      = saidas.armar_disparo;
  assign disparar           = saidas.disparar;
  assign recarregar_disparo = saidas.recarregar_disparo;
  assign conta_municao      = saidas.conta_municao;
  assign db_estado          = estado;

endmodule

// File: tb/tb_torreta_uc.sv
// Scoreboard bench for torreta_uc: stimulus queues expected state visits,
// a negedge monitor pops one per state change and checks strobes every cycle.
module tb_torreta_uc;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ligar = 1'b0, carregar = 1'b0;
  logic       medida_pronto = 1'b0, envio_pronto = 1'b0, fim_tempo = 1'b0;
  logic       ameaca_detectada = 1'b0, municao_carregada = 1'b0;
  logic       disparo_pronto = 1'b0, fim_disparo = 1'b0, disparo_carregado = 1'b0;
  logic       medir, transmitir, girar, conta_tempo, armar_disparo, disparar;
  logic       recarregar_disparo, conta_municao, erro_medida;
  logic [3:0] db_estado;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] st;
    logic       erro;
    int         dur;   // expected cycles in state; 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   run;
  bit   mon_en = 1'b0;

  localparam int P_MEDIDA = 0, P_ENVIO = 1, P_TEMPO = 2, P_PRONTO = 3, P_FIM = 4, P_CARREG = 5;

  torreta_uc #(.TIMEOUT_MEDIDA(100), .N_TIMEOUT(22)) dut (
    .clock              (clock),
    .reset              (reset),
    .ligar              (ligar),
    .carregar           (carregar),
    .medida_pronto      (medida_pronto),
    .envio_pronto       (envio_pronto),
    .fim_tempo          (fim_tempo),
    .ameaca_detectada   (ameaca_detectada),
    .municao_carregada  (municao_carregada),
    .disparo_pronto     (disparo_pronto),
    .fim_disparo        (fim_disparo),
    .disparo_carregado  (disparo_carregado),
    .medir              (medir),
    .transmitir         (transmitir),
    .girar              (girar),
    .conta_tempo        (conta_tempo),
    .armar_disparo      (armar_disparo),
    .disparar           (disparar),
    .recarregar_disparo (recarregar_disparo),
    .conta_municao      (conta_municao),
    .erro_medida        (erro_medida),
    .db_estado          (db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] strobes_now();
    return {medir, transmitir, girar, conta_tempo, armar_disparo, disparar,
            recarregar_disparo, conta_municao};
  endfunction

  // Strobe table: {medir,transmitir,girar,conta_tempo,armar,disparar,recarregar,conta_municao}
  function automatic logic [7:0] strobes_exp(logic [3:0] st);
    case (st)
      4'h2:    return 8'b1000_0000;
      4'h4:    return 8'b0100_0000;
      4'h8:    return 8'b0010_0000;
      4'h7:    return 8'b0001_0000;
      4'h9:    return 8'b0000_1000;
      4'hA:    return 8'b0000_0100;
      4'hB:    return 8'b0000_0010;
      4'hC:    return 8'b0000_0001;
      default: return 8'b0000_0000;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(logic [3:0] st, logic erro, int dur);
    exp_t e;
    e.st = st; e.erro = erro; e.dur = dur;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(logic [3:0] st);
    for (int i = 0; i < 400; i++) begin
      if (db_estado == st) break;
      step();
    end
    check("wait_state", {28'd0, db_estado}, {28'd0, st});
  endtask

  // Wait for state st, let it run k cycles in total, leaving with a 1-cycle status pulse.
  task automatic hold_then_pulse(logic [3:0] st, int k, int which);
    wait_state(st);
    repeat (k - 1) step();
    case (which)
      P_MEDIDA: medida_pronto     = 1'b1;
      P_ENVIO:  envio_pronto      = 1'b1;
      P_TEMPO:  fim_tempo         = 1'b1;
      P_PRONTO: disparo_pronto    = 1'b1;
      P_FIM:    fim_disparo       = 1'b1;
      default:  disparo_carregado = 1'b1;
    endcase
    step();
    {medida_pronto, envio_pronto, fim_tempo, disparo_pronto, fim_disparo, disparo_carregado} = '0;
  endtask

  // Monitor: one scoreboard pop per observed state change, strobes every cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      if (db_estado !== cur.st) begin
        if (cur.dur != 0) check($sformatf("dur_%0h", cur.st), run, cur.dur);
        if (exp_q.size() == 0) check("unexpected_state", {28'd0, db_estado}, {28'd0, cur.st});
        else begin
          cur = exp_q.pop_front();
          check("state", {28'd0, db_estado}, {28'd0, cur.st});
        end
        run = 1;
      end else begin
        run++;
      end
      check($sformatf("strobes_in_%0h", cur.st), {24'd0, strobes_now()}, {24'd0, strobes_exp(cur.st)});
      check("erro_medida", {31'd0, erro_medida}, {31'd0, cur.erro});
    end
  end

  initial begin
    cur.st = 4'h0; cur.erro = 1'b0; cur.dur = 0;
    run = 0;

    repeat (3) @(posedge clock);
    #1;
    check("reset_state", {28'd0, db_estado}, 32'h0);
    check("reset_strobes", {24'd0, strobes_now()}, 32'h0);
    check("reset_erro", {31'd0, erro_medida}, 32'h0);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Normal step, no threat
    ligar = 1'b1;
    push(4'h1,0,1); push(4'h2,0,1); push(4'h3,0,10); push(4'h4,0,1); push(4'h5,0,20);
    push(4'h6,0,1); push(4'h7,0,50); push(4'h8,0,1); push(4'h2,0,1);
    hold_then_pulse(4'h3, 10, P_MEDIDA);
    hold_then_pulse(4'h5, 20, P_ENVIO);
    hold_then_pulse(4'h7, 50, P_TEMPO);

    // Threat with ammunition: arm, fire, reload
    ameaca_detectada = 1'b1; municao_carregada = 1'b1;
    push(4'h3,0,10); push(4'h4,0,1); push(4'h5,0,20); push(4'h6,0,1); push(4'h9,0,100);
    push(4'hA,0,100); push(4'hB,0,100); push(4'h7,0,50); push(4'h8,0,1); push(4'h2,0,1);
    hold_then_pulse(4'h3, 10, P_MEDIDA);
    hold_then_pulse(4'h5, 20, P_ENVIO);
    hold_then_pulse(4'h9, 100, P_PRONTO);
    hold_then_pulse(4'hA, 100, P_FIM);
    hold_then_pulse(4'hB, 100, P_CARREG);
    hold_then_pulse(4'h7, 50, P_TEMPO);

    // Threat without ammunition: no arming
    municao_carregada = 1'b0;
    push(4'h3,0,10); push(4'h4,0,1); push(4'h5,0,20); push(4'h6,0,1);
    push(4'h7,0,50); push(4'h8,0,1); push(4'h2,0,1);
    hold_then_pulse(4'h3, 10, P_MEDIDA);
    hold_then_pulse(4'h5, 20, P_ENVIO);
    hold_then_pulse(4'h7, 50, P_TEMPO);

    // Measurement timeout, then a good measurement clears the error
    ameaca_detectada = 1'b0;
    push(4'h3,0,100); push(4'h7,1,50); push(4'h8,1,1); push(4'h2,1,1); push(4'h3,1,10);
    push(4'h4,0,1); push(4'h5,0,20); push(4'h6,0,1); push(4'h7,0,50); push(4'h8,0,1); push(4'h2,0,1);
    hold_then_pulse(4'h7, 50, P_TEMPO);
    hold_then_pulse(4'h3, 10, P_MEDIDA);
    hold_then_pulse(4'h5, 20, P_ENVIO);
    hold_then_pulse(4'h7, 50, P_TEMPO);

    // ligar drops mid-shot: shot completes, wait state exits at once
    ameaca_detectada = 1'b1; municao_carregada = 1'b1;
    push(4'h3,0,10); push(4'h4,0,1); push(4'h5,0,20); push(4'h6,0,1); push(4'h9,0,100);
    push(4'hA,0,100); push(4'hB,0,100); push(4'h7,0,1); push(4'h0,0,0);
    hold_then_pulse(4'h3, 10, P_MEDIDA);
    hold_then_pulse(4'h5, 20, P_ENVIO);
    hold_then_pulse(4'h9, 100, P_PRONTO);
    wait_state(4'hA);
    ligar = 1'b0;
    hold_then_pulse(4'hA, 100, P_FIM);
    hold_then_pulse(4'hB, 100, P_CARREG);
    wait_state(4'h0);

    // ligar drops while in GIRA
    ameaca_detectada = 1'b0;
    ligar = 1'b1;
    push(4'h1,0,1); push(4'h2,0,1); push(4'h3,0,10); push(4'h4,0,1); push(4'h5,0,20);
    push(4'h6,0,1); push(4'h7,0,50); push(4'h8,0,1); push(4'h0,0,0);
    hold_then_pulse(4'h3, 10, P_MEDIDA);
    hold_then_pulse(4'h5, 20, P_ENVIO);
    hold_then_pulse(4'h7, 50, P_TEMPO);
    ligar = 1'b0;
    wait_state(4'h0);

    // Manual load: carregar held 5 cycles
    push(4'hC,0,5); push(4'h0,0,0);
    carregar = 1'b1;
    repeat (5) step();
    carregar = 1'b0;
    repeat (3) step();

    // Async reset during RECARREGA
    ameaca_detectada = 1'b1; municao_carregada = 1'b1;
    ligar = 1'b1;
    push(4'h1,0,1); push(4'h2,0,1); push(4'h3,0,10); push(4'h4,0,1); push(4'h5,0,20);
    push(4'h6,0,1); push(4'h9,0,100); push(4'hA,0,100); push(4'hB,0,0); push(4'h0,0,0);
    hold_then_pulse(4'h3, 10, P_MEDIDA);
    hold_then_pulse(4'h5, 20, P_ENVIO);
    hold_then_pulse(4'h9, 100, P_PRONTO);
    hold_then_pulse(4'hA, 100, P_FIM);
    wait_state(4'hB);
    repeat (10) step();
    @(negedge clock);
    #2;
    reset = 1'b0;
    ligar = 1'b0;
    #1;
    check("async_reset_state", {28'd0, db_estado}, 32'h0);
    check("async_reset_strobes", {24'd0, strobes_now()}, 32'h0);
    @(negedge clock);
    #2;
    reset = 1'b1;

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    repeat (3) step();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
